// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: hex-to-segment table,
// decimal-point bit position, scan FSM states and the per-digit pattern helper.
package seg_pkg;

  localparam int SEG_DP = 0;

  // Active-high a..g, a in the MSB.
  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  function automatic logic [7:0] seg_pattern(input logic [3:0] hex,
                                             input logic       dp,
                                             input logic       blank);
    logic [7:0] pat;
    pat = 8'h00;
    if (blank) begin
      pat = 8'h00;
    end else begin
      pat[7:1]    = HEX_SEG[hex];
      pat[SEG_DP] = dp;
    end
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_counter.sv
// Slot prescaler and digit-index wrap for seg_scan_driver. Counting runs only
// while 'run' is high; otherwise both counters sit at zero.
module seg_scan_counter
  import seg_pkg::*;
#(
  parameter  int DIV        = 10,
  parameter  int NUM_DIGITS = 8,
  localparam int CNT_W      = (DIV > 1) ? $clog2(DIV) : 1,
  localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] digit_idx,
  output logic [IDX_W-1:0] idx_next
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Next-count and slot-wrap logic.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    tick  = 1'b0;
    if (!run) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_W'(DIV - 1)) begin
      tick  = 1'b1;
      cnt_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt       = cnt_q;
  assign digit_idx = idx_q;
  assign idx_next  = idx_d;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with fully registered outputs.
// Optional anti-ghosting dead time at each slot start: define SEG_SCAN_GUARD_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int NUM_DIGITS   = 8,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  output logic [NUM_DIGITS-1:0]         tub_sel,
  output logic [7:0]                    seg,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          slot_start
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  generate
    if (DIV < 2) begin : g_div_chk
      $error("seg_scan_driver: CLK_HZ/SCAN_HZ must be at least 2");
    end
    if (NUM_DIGITS < 2) begin : g_num_chk
      $error("seg_scan_driver: NUM_DIGITS must be at least 2");
    end
    if (GUARD_CYCLES >= DIV) begin : g_guard_chk
      $error("seg_scan_driver: GUARD_CYCLES must be below CLK_HZ/SCAN_HZ");
    end
  endgenerate

  scan_state_e           state_q, state_d;
  logic [NUM_DIGITS-1:0] tub_sel_q, tub_sel_d;
  logic [7:0]            seg_q, seg_d;
  logic                  slot_start_q, slot_start_d;

  logic                  run_s;
  logic                  tick_s;
  logic                  guard_s;
  logic [CNT_W-1:0]      cnt_s;
  logic [IDX_W-1:0]      idx_s;
  logic [IDX_W-1:0]      idx_next_s;
  logic [NUM_DIGITS-1:0] sel_s;
  logic [7:0]            load_seg_s;

  assign run_s = (state_q == SCAN) && en;

  seg_scan_counter #(
    .DIV        (DIV),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run_s),
    .tick      (tick_s),
    .cnt       (cnt_s),
    .digit_idx (idx_s),
    .idx_next  (idx_next_s)
  );

  // Select and pattern for the digit that will own the next cycle.
  assign sel_s      = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_next_s;
  assign load_seg_s = seg_pattern(digits[{idx_next_s, 2'b00} +: 4],
                                  dp_mask[idx_next_s], blank_mask[idx_next_s]);

`ifdef SEG_SCAN_GUARD_EN
  // Guard decided on the count the next cycle will hold: zero at a slot start.
  assign guard_s = (!run_s || tick_s) ? (GUARD_CYCLES > 0)
                                      : ((int'(cnt_s) + 1) < GUARD_CYCLES);
`else
  logic unused_cnt_s;
  assign unused_cnt_s = ^cnt_s;
  assign guard_s      = 1'b0;
`endif

  // Next-state and next-output logic of the scan FSM.
  always_comb begin
    state_d      = state_q;
    tub_sel_d    = tub_sel_q;
    seg_d        = seg_q;
    slot_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d      = SCAN;
          seg_d        = load_seg_s;
          tub_sel_d    = guard_s ? '0 : sel_s;
          slot_start_d = 1'b1;
        end else begin
          tub_sel_d = '0;
          seg_d     = 8'h00;
        end
      end
      SCAN: begin
        if (!en) begin
          state_d   = IDLE;
          tub_sel_d = '0;
          seg_d     = 8'h00;
        end else begin
          if (tick_s) begin
            seg_d        = load_seg_s;
            slot_start_d = 1'b1;
          end else begin
            seg_d = seg_q;
          end
          tub_sel_d = guard_s ? '0 : sel_s;
        end
      end
      default: begin
        state_d   = IDLE;
        tub_sel_d = '0;
        seg_d     = 8'h00;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tub_sel_q    <= '0;
      seg_q        <= 8'h00;
      slot_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tub_sel_q    <= tub_sel_d;
      seg_q        <= seg_d;
      slot_start_q <= slot_start_d;
    end
  end

  assign tub_sel    = tub_sel_q;
  assign seg        = seg_q;
  assign digit_idx  = idx_s;
  assign slot_start = slot_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIV=10, 4 digits, guard 3):
// cycle model feeds a scoreboard queue, plus directed checks on key points.
module tb_seg_scan_driver;

  localparam int DIV = 10;
`ifdef SEG_SCAN_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic [3:0]  tub_sel;
  logic [7:0]  seg;
  logic [1:0]  digit_idx;
  logic        slot_start;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] tub;
    logic [7:0] seg;
    logic [1:0] idx;
    logic       ss;
  } exp_t;

  exp_t sb_q[$];

  bit         m_run;
  int         m_cnt;
  int         m_idx;
  logic [7:0] m_seg;
  logic       m_ss;

  seg_scan_driver #(
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .NUM_DIGITS   (4),
    .GUARD_CYCLES (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .tub_sel    (tub_sel),
    .seg        (seg),
    .digit_idx  (digit_idx),
    .slot_start (slot_start)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_pat(input logic [3:0] h, input logic dp, input logic bl);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1111110;  4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;  4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;  4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;  4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;  4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;  4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;  4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;  default: s = 7'b1000111;
    endcase
    return bl ? 8'h00 : {s, dp};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_load(input int k);
    return exp_pat(digits[4*k +: 4], dp_mask[k], blank_mask[k]);
  endfunction

  // Advance the reference model over the coming edge and queue its prediction.
  task automatic model_step();
    exp_t e;
    if (!m_run) begin
      m_cnt = 0;
      m_idx = 0;
      if (en) begin
        m_run = 1'b1;
        m_seg = model_load(0);
        m_ss  = 1'b1;
      end else begin
        m_seg = 8'h00;
        m_ss  = 1'b0;
      end
    end else if (!en) begin
      m_run = 1'b0;
      m_cnt = 0;
      m_idx = 0;
      m_seg = 8'h00;
      m_ss  = 1'b0;
    end else if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 4;
      m_seg = model_load(m_idx);
      m_ss  = 1'b1;
    end else begin
      m_cnt = m_cnt + 1;
      m_ss  = 1'b0;
    end
    e.tub = (m_run && (!GUARD_ON || m_cnt >= 3)) ? (4'b0001 << m_idx) : 4'b0000;
    e.seg = m_seg;
    e.idx = m_idx[1:0];
    e.ss  = m_ss;
    sb_q.push_back(e);
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_cnt = 0;
    m_idx = 0;
    m_seg = 8'h00;
    m_ss  = 1'b0;
    sb_q.delete();
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_tub_sel", {28'd0, tub_sel}, {28'd0, e.tub});
    chk("sb_seg", {24'd0, seg}, {24'd0, e.seg});
    chk("sb_digit_idx", {30'd0, digit_idx}, {30'd0, e.idx});
    chk("sb_slot_start", {31'd0, slot_start}, {31'd0, e.ss});
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Directed check on the first cycle of a slot for digit k.
  task automatic chk_load(input string tag, input int k, input logic [7:0] exp_seg);
    logic [3:0] exp_tub;
    exp_tub = GUARD_ON ? 4'b0000 : (4'b0001 << k);
    chk({tag, "_seg"}, {24'd0, seg}, {24'd0, exp_seg});
    chk({tag, "_tub"}, {28'd0, tub_sel}, {28'd0, exp_tub});
    chk({tag, "_idx"}, {30'd0, digit_idx}, k);
    chk({tag, "_ss"}, {31'd0, slot_start}, 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tub"}, {28'd0, tub_sel}, 32'd0);
    chk({tag, "_seg"}, {24'd0, seg}, 32'd0);
    chk({tag, "_idx"}, {30'd0, digit_idx}, 32'd0);
    chk({tag, "_ss"}, {31'd0, slot_start}, 32'd0);
  endtask

  logic [7:0] s1_seg [0:3];
  logic [7:0] s2_seg [0:3];

  initial begin
    s1_seg[0] = 8'b1111_1100; s1_seg[1] = 8'b0110_0000;
    s1_seg[2] = 8'b1101_1010; s1_seg[3] = 8'b1111_0010;
    s2_seg[0] = 8'b1001_1101; s2_seg[1] = 8'b0000_0000;
    s2_seg[2] = 8'b1001_1111; s2_seg[3] = 8'b1000_1110;

    rst_n      = 1'b0;
    en         = 1'b0;
    digits     = 16'h3210;
    dp_mask    = 4'b0000;
    blank_mask = 4'b0000;
    model_reset();
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycles(2);
    chk_zero("idle_en0");

    // Basic scan of 3210 across a full frame plus wrap.
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_load("s1_slot", k % 4, s1_seg[k % 4]);
      run_cycles(DIV - 1);
    end

    // Masks and upper hex digits; re-enable restarts at digit 0.
    en = 1'b0;
    cyc();
    chk_zero("s2_off");
    digits     = 16'hFEDC;
    dp_mask    = 4'b0101;
    blank_mask = 4'b0010;
    en         = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk_load("s2_slot", k, s2_seg[k]);
      run_cycles(DIV - 1);
    end

    // Mid-slot input change is invisible until that digit's next slot.
    en = 1'b0;
    cyc();
    digits     = 16'h3210;
    dp_mask    = 4'b0000;
    blank_mask = 4'b0000;
    en         = 1'b1;
    cyc();
    chk_load("s3_first", 0, 8'b1111_1100);
    run_cycles(3);
    digits[3:0] = 4'h8;
    run_cycles(6);
    chk("s3_hold_seg", {24'd0, seg}, 32'hFC);
    run_cycles(30);
    cyc();
    chk_load("s3_next_frame", 0, 8'b1111_1110);

    // Drop enable in slot 2, then re-enable.
    run_cycles(23);
    chk("s4_in_slot2", {30'd0, digit_idx}, 32'd2);
    en = 1'b0;
    cyc();
    chk_zero("s4_drop");
    en = 1'b1;
    cyc();
    chk_load("s4_restart", 0, 8'b1111_1110);

    // Asynchronous reset mid-slot, no clock edge in between.
    digits = 16'h3210;
    run_cycles(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("s5_async");
    model_reset();
    @(posedge clk);
    #1;
    chk_zero("s5_held");
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk_load("s5_slot", k, s1_seg[k]);
      run_cycles(DIV - 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
